// File: rtl/uart_cmd_sequencer_pkg.sv
// Shared constants and state encoding for the UART command sequencer.
package uart_cmd_sequencer_pkg;

  localparam int unsigned FUN_W = 4;

  localparam logic [7:0] OP_WRITE   = 8'hAA;
  localparam logic [7:0] OP_READ    = 8'hBB;
  localparam logic [7:0] OP_ALU_OPS = 8'hCC;
  localparam logic [7:0] OP_ALU_NOP = 8'hDD;

  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_OP_A,
    ST_OP_B,
    ST_ALU_FUN,
    ST_ALU_WAIT,
    ST_TX_LO,
    ST_TX_HI,
    ST_TX_RD
  } state_t;

endpackage

// File: rtl/uart_cmd_sequencer.sv
// Parses UART command frames into register-file / ALU strobes and returns results to the transmitter.
module uart_cmd_sequencer
  import uart_cmd_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  output logic                    RF_WR_EN,
  output logic                    RF_RD_EN,
  output logic [ADDR_WIDTH-1:0]   RF_ADDR,
  output logic [DATA_WIDTH-1:0]   RF_WR_DATA,
  input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
  input  logic                    RF_RD_VLD,
  output logic                    ALU_EN,
  output logic [FUN_W-1:0]        ALU_FUN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  output logic                    CLK_GATE_EN,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  input  logic                    TX_READY,
  output logic                    CMD_DROP
);

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_nxt;
  logic [2*DATA_WIDTH-1:0] result_q, result_nxt;

  logic                    rf_wr_en_nxt, rf_rd_en_nxt, alu_en_nxt, cmd_drop_nxt;
  logic [ADDR_WIDTH-1:0]   rf_addr_nxt;
  logic [DATA_WIDTH-1:0]   rf_wr_data_nxt, tx_data_nxt;
  logic [FUN_W-1:0]        alu_fun_nxt;
  logic                    tx_vld_nxt, gate_nxt;
  logic                    tx_accept;

  assign tx_accept = TX_D_VLD && TX_READY;

  // Next-state and next-output decode; strobes default low, data outputs hold.
  always_comb begin
    state_nxt      = state;
    wr_addr_nxt    = wr_addr_q;
    result_nxt     = result_q;
    rf_wr_en_nxt   = 1'b0;
    rf_rd_en_nxt   = 1'b0;
    alu_en_nxt     = 1'b0;
    cmd_drop_nxt   = 1'b0;
    rf_addr_nxt    = RF_ADDR;
    rf_wr_data_nxt = RF_WR_DATA;
    alu_fun_nxt    = ALU_FUN;
    tx_data_nxt    = TX_P_DATA;
    tx_vld_nxt     = TX_D_VLD;
    gate_nxt       = CLK_GATE_EN;

    case (state)
      ST_IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == OP_WRITE) begin
            state_nxt = ST_WR_ADDR;
          end else if (RX_P_DATA == OP_READ) begin
            state_nxt = ST_RD_ADDR;
          end else if (RX_P_DATA == OP_ALU_OPS) begin
            state_nxt = ST_OP_A;
            gate_nxt  = 1'b1;
          end else if (RX_P_DATA == OP_ALU_NOP) begin
            state_nxt = ST_ALU_FUN;
            gate_nxt  = 1'b1;
          end else begin
            cmd_drop_nxt = 1'b1;
          end
        end
      end
      ST_WR_ADDR: begin
        if (RX_D_VLD) begin
          wr_addr_nxt = RX_P_DATA[ADDR_WIDTH-1:0];
          state_nxt   = ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        if (RX_D_VLD) begin
          rf_wr_en_nxt   = 1'b1;
          rf_addr_nxt    = wr_addr_q;
          rf_wr_data_nxt = RX_P_DATA;
          state_nxt      = ST_IDLE;
        end
      end
      ST_RD_ADDR: begin
        if (RX_D_VLD) begin
          rf_rd_en_nxt = 1'b1;
          rf_addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_nxt    = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        cmd_drop_nxt = RX_D_VLD;
        if (RF_RD_VLD) begin
          tx_data_nxt = RF_RD_DATA;
          tx_vld_nxt  = 1'b1;
          state_nxt   = ST_TX_RD;
        end
      end
      ST_OP_A: begin
        if (RX_D_VLD) begin
          rf_wr_en_nxt   = 1'b1;
          rf_addr_nxt    = ADDR_WIDTH'(OPA_ADDR);
          rf_wr_data_nxt = RX_P_DATA;
          state_nxt      = ST_OP_B;
        end
      end
      ST_OP_B: begin
        if (RX_D_VLD) begin
          rf_wr_en_nxt   = 1'b1;
          rf_addr_nxt    = ADDR_WIDTH'(OPB_ADDR);
          rf_wr_data_nxt = RX_P_DATA;
          state_nxt      = ST_ALU_FUN;
        end
      end
      ST_ALU_FUN: begin
        if (RX_D_VLD) begin
          alu_en_nxt  = 1'b1;
          alu_fun_nxt = RX_P_DATA[FUN_W-1:0];
          state_nxt   = ST_ALU_WAIT;
        end
      end
      ST_ALU_WAIT: begin
        cmd_drop_nxt = RX_D_VLD;
        if (ALU_OUT_VLD) begin
          result_nxt  = ALU_OUT;
          tx_data_nxt = ALU_OUT[DATA_WIDTH-1:0];
          tx_vld_nxt  = 1'b1;
          gate_nxt    = 1'b0;
          state_nxt   = ST_TX_LO;
        end
      end
      ST_TX_LO: begin
        cmd_drop_nxt = RX_D_VLD;
        if (tx_accept) begin
          tx_data_nxt = result_q[2*DATA_WIDTH-1:DATA_WIDTH];
          state_nxt   = ST_TX_HI;
        end
      end
      ST_TX_HI, ST_TX_RD: begin
        cmd_drop_nxt = RX_D_VLD;
        if (tx_accept) begin
          tx_vld_nxt = 1'b0;
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, holding registers and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      wr_addr_q   <= '0;
      result_q    <= '0;
      RF_WR_EN    <= 1'b0;
      RF_RD_EN    <= 1'b0;
      RF_ADDR     <= '0;
      RF_WR_DATA  <= '0;
      ALU_EN      <= 1'b0;
      ALU_FUN     <= '0;
      CLK_GATE_EN <= 1'b0;
      TX_P_DATA   <= '0;
      TX_D_VLD    <= 1'b0;
      CMD_DROP    <= 1'b0;
    end else begin
      state       <= state_nxt;
      wr_addr_q   <= wr_addr_nxt;
      result_q    <= result_nxt;
      RF_WR_EN    <= rf_wr_en_nxt;
      RF_RD_EN    <= rf_rd_en_nxt;
      RF_ADDR     <= rf_addr_nxt;
      RF_WR_DATA  <= rf_wr_data_nxt;
      ALU_EN      <= alu_en_nxt;
      ALU_FUN     <= alu_fun_nxt;
      CLK_GATE_EN <= gate_nxt;
      TX_P_DATA   <= tx_data_nxt;
      TX_D_VLD    <= tx_vld_nxt;
      CMD_DROP    <= cmd_drop_nxt;
    end
  end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed bench for uart_cmd_sequencer: frames, results, drops and mid-frame reset.
module tb_uart_cmd_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic        RF_WR_EN, RF_RD_EN;
  logic [3:0]  RF_ADDR;
  logic [7:0]  RF_WR_DATA;
  logic [7:0]  RF_RD_DATA;
  logic        RF_RD_VLD;
  logic        ALU_EN;
  logic [3:0]  ALU_FUN;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VLD;
  logic        CLK_GATE_EN;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        TX_READY;
  logic        CMD_DROP;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  logic [7:0] tx_q[$];

  uart_cmd_sequencer dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN), .RF_ADDR(RF_ADDR),
    .RF_WR_DATA(RF_WR_DATA), .RF_RD_DATA(RF_RD_DATA), .RF_RD_VLD(RF_RD_VLD),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
    .CLK_GATE_EN(CLK_GATE_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
    .TX_READY(TX_READY), .CMD_DROP(CMD_DROP)
  );

  always #5 CLK = ~CLK;

  // Record every accepted TX byte and every register-file write.
  always @(posedge CLK) begin
    if (TX_D_VLD && TX_READY) tx_q.push_back(TX_P_DATA);
    if (RF_WR_EN === 1'b1) wr_cnt++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    tick();
    RX_D_VLD  = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RX_P_DATA = 8'h00; RX_D_VLD = 1'b0; RF_RD_DATA = 8'h00; RF_RD_VLD = 1'b0;
    ALU_OUT = 16'h0000; ALU_OUT_VLD = 1'b0; TX_READY = 1'b0;
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    checks++;
    if ({RF_WR_EN, RF_RD_EN, RF_ADDR, RF_WR_DATA, ALU_EN, ALU_FUN, CLK_GATE_EN,
         TX_P_DATA, TX_D_VLD, CMD_DROP} !== 30'h0) begin
      failures++;
      $display("FAIL reset_outputs: got wr=%b rd=%b addr=%h wd=%h alu=%b fun=%h gate=%b tx=%h txv=%b drop=%b, want all 0",
               RF_WR_EN, RF_RD_EN, RF_ADDR, RF_WR_DATA, ALU_EN, ALU_FUN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD, CMD_DROP);
    end
  endtask

  task automatic test_write();
    send_byte(8'hAA);
    send_byte(8'h05);
    checks++;
    if (RF_WR_EN !== 1'b0) begin failures++; $display("FAIL wr_early: wr_en=%b want 0", RF_WR_EN); end
    send_byte(8'h3C);
    checks++;
    if ({RF_WR_EN, RF_ADDR, RF_WR_DATA, CLK_GATE_EN} !== {1'b1, 4'h5, 8'h3C, 1'b0}) begin
      failures++;
      $display("FAIL wr_strobe: wr=%b addr=%h data=%h gate=%b, want 1 5 3c 0", RF_WR_EN, RF_ADDR, RF_WR_DATA, CLK_GATE_EN);
    end
    tick();
    checks++;
    if ({RF_WR_EN, RF_ADDR, RF_WR_DATA} !== {1'b0, 4'h5, 8'h3C}) begin
      failures++;
      $display("FAIL wr_one_cycle: wr=%b addr=%h data=%h, want 0 5 3c", RF_WR_EN, RF_ADDR, RF_WR_DATA);
    end
  endtask

  task automatic test_read();
    int hold_bad = 0;
    tx_q.delete();
    send_byte(8'hBB);
    send_byte(8'h02);
    checks++;
    if ({RF_RD_EN, RF_ADDR} !== {1'b1, 4'h2}) begin
      failures++;
      $display("FAIL rd_strobe: rd=%b addr=%h, want 1 2", RF_RD_EN, RF_ADDR);
    end
    tick(); tick();
    RF_RD_DATA = 8'h7E; RF_RD_VLD = 1'b1;
    tick();
    RF_RD_VLD = 1'b0; RF_RD_DATA = 8'h00;
    checks++;
    if ({TX_D_VLD, TX_P_DATA} !== {1'b1, 8'h7E}) begin
      failures++;
      $display("FAIL rd_tx_rise: txv=%b tx=%h, want 1 7e", TX_D_VLD, TX_P_DATA);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if ({TX_D_VLD, TX_P_DATA} !== {1'b1, 8'h7E}) hold_bad++;
    end
    checks++;
    if (hold_bad !== 0) begin failures++; $display("FAIL rd_tx_hold: %0d bad cycles, want 0", hold_bad); end
    // Byte arriving with the acceptance is dropped; FSM returns to IDLE.
    TX_READY = 1'b1;
    send_byte(8'hAA);
    TX_READY = 1'b0;
    checks++;
    if ({TX_D_VLD, CMD_DROP} !== 2'b01) begin
      failures++;
      $display("FAIL rd_accept_drop: txv=%b drop=%b, want 0 1", TX_D_VLD, CMD_DROP);
    end
    checks++;
    if (tx_q.size() != 1 || tx_q[0] !== 8'h7E) begin
      failures++;
      $display("FAIL rd_tx_count: size=%0d first=%h, want 1 7e", tx_q.size(), tx_q[0]);
    end
    // 0x11 must be rejected from IDLE, proving the 0xAA was not taken as an opcode.
    send_byte(8'h11);
    checks++;
    if ({CMD_DROP, RF_WR_EN, RF_RD_EN, ALU_EN} !== 4'b1000) begin
      failures++;
      $display("FAIL idle_drop: drop=%b wr=%b rd=%b alu=%b, want 1 0 0 0", CMD_DROP, RF_WR_EN, RF_RD_EN, ALU_EN);
    end
    tick();
    checks++;
    if (CMD_DROP !== 1'b0) begin failures++; $display("FAIL drop_pulse: drop=%b want 0", CMD_DROP); end
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'hFF);
    checks++;
    if ({RF_WR_EN, RF_ADDR, RF_WR_DATA} !== {1'b1, 4'h1, 8'hFF}) begin
      failures++;
      $display("FAIL wr_after_drop: wr=%b addr=%h data=%h, want 1 1 ff", RF_WR_EN, RF_ADDR, RF_WR_DATA);
    end
    tick();
  endtask

  task automatic test_alu_ops();
    int gate_bad = 0;
    tx_q.delete();
    send_byte(8'hCC);
    if (CLK_GATE_EN !== 1'b1) gate_bad++;
    send_byte(8'h12);
    checks++;
    if ({RF_WR_EN, RF_ADDR, RF_WR_DATA} !== {1'b1, 4'h0, 8'h12}) begin
      failures++;
      $display("FAIL alu_opa: wr=%b addr=%h data=%h, want 1 0 12", RF_WR_EN, RF_ADDR, RF_WR_DATA);
    end
    if (CLK_GATE_EN !== 1'b1) gate_bad++;
    send_byte(8'h34);
    checks++;
    if ({RF_WR_EN, RF_ADDR, RF_WR_DATA} !== {1'b1, 4'h1, 8'h34}) begin
      failures++;
      $display("FAIL alu_opb: wr=%b addr=%h data=%h, want 1 1 34", RF_WR_EN, RF_ADDR, RF_WR_DATA);
    end
    if (CLK_GATE_EN !== 1'b1) gate_bad++;
    send_byte(8'hF1);
    checks++;
    if ({ALU_EN, ALU_FUN, RF_WR_EN} !== {1'b1, 4'h1, 1'b0}) begin
      failures++;
      $display("FAIL alu_en: alu=%b fun=%h wr=%b, want 1 1 0", ALU_EN, ALU_FUN, RF_WR_EN);
    end
    for (int i = 0; i < 2; i++) begin
      if (CLK_GATE_EN !== 1'b1) gate_bad++;
      tick();
    end
    ALU_OUT = 16'hABCD; ALU_OUT_VLD = 1'b1;
    if (CLK_GATE_EN !== 1'b1) gate_bad++;
    tick();
    ALU_OUT_VLD = 1'b0; ALU_OUT = 16'h0000;
    checks++;
    if (gate_bad !== 0) begin failures++; $display("FAIL alu_gate_high: %0d low cycles, want 0", gate_bad); end
    checks++;
    if ({TX_D_VLD, TX_P_DATA, CLK_GATE_EN} !== {1'b1, 8'hCD, 1'b0}) begin
      failures++;
      $display("FAIL alu_tx_lo: txv=%b tx=%h gate=%b, want 1 cd 0", TX_D_VLD, TX_P_DATA, CLK_GATE_EN);
    end
    TX_READY = 1'b1;
    tick();
    checks++;
    if ({TX_D_VLD, TX_P_DATA} !== {1'b1, 8'hAB}) begin
      failures++;
      $display("FAIL alu_tx_hi: txv=%b tx=%h, want 1 ab", TX_D_VLD, TX_P_DATA);
    end
    tick();
    TX_READY = 1'b0;
    checks++;
    if (tx_q.size() != 2 || tx_q[0] !== 8'hCD || tx_q[1] !== 8'hAB || TX_D_VLD !== 1'b0) begin
      failures++;
      $display("FAIL alu_tx_seq: size=%0d b0=%h b1=%h txv=%b, want 2 cd ab 0", tx_q.size(), tx_q[0], tx_q[1], TX_D_VLD);
    end
  endtask

  task automatic test_alu_nop();
    int wr_before = wr_cnt;
    tx_q.delete();
    send_byte(8'hDD);
    checks++;
    if (CLK_GATE_EN !== 1'b1) begin failures++; $display("FAIL nop_gate: gate=%b want 1", CLK_GATE_EN); end
    send_byte(8'h03);
    checks++;
    if ({ALU_EN, ALU_FUN} !== {1'b1, 4'h3}) begin
      failures++;
      $display("FAIL nop_alu_en: alu=%b fun=%h, want 1 3", ALU_EN, ALU_FUN);
    end
    tick();
    send_byte(8'h55);
    checks++;
    if ({CMD_DROP, RF_WR_EN, ALU_EN, CLK_GATE_EN} !== 4'b1001) begin
      failures++;
      $display("FAIL wait_drop: drop=%b wr=%b alu=%b gate=%b, want 1 0 0 1", CMD_DROP, RF_WR_EN, ALU_EN, CLK_GATE_EN);
    end
    ALU_OUT = 16'h0102; ALU_OUT_VLD = 1'b1;
    tick();
    ALU_OUT_VLD = 1'b0;
    checks++;
    if ({TX_D_VLD, TX_P_DATA, CMD_DROP} !== {1'b1, 8'h02, 1'b0}) begin
      failures++;
      $display("FAIL nop_tx_lo: txv=%b tx=%h drop=%b, want 1 02 0", TX_D_VLD, TX_P_DATA, CMD_DROP);
    end
    TX_READY = 1'b1;
    tick(); tick();
    TX_READY = 1'b0;
    checks++;
    if (tx_q.size() != 2 || tx_q[0] !== 8'h02 || tx_q[1] !== 8'h01 || wr_cnt != wr_before) begin
      failures++;
      $display("FAIL nop_result: size=%0d b0=%h b1=%h writes=%0d, want 2 02 01 0", tx_q.size(), tx_q[0], tx_q[1], wr_cnt - wr_before);
    end
  endtask

  task automatic test_reset_mid_frame();
    tx_q.delete();
    send_byte(8'hCC);
    send_byte(8'h12);
    do_reset();
    checks++;
    if ({RF_WR_EN, RF_RD_EN, RF_ADDR, RF_WR_DATA, ALU_EN, ALU_FUN, CLK_GATE_EN,
         TX_P_DATA, TX_D_VLD, CMD_DROP} !== 30'h0) begin
      failures++;
      $display("FAIL midframe_reset: wr=%b rd=%b addr=%h wd=%h alu=%b gate=%b txv=%b, want all 0",
               RF_WR_EN, RF_RD_EN, RF_ADDR, RF_WR_DATA, ALU_EN, CLK_GATE_EN, TX_D_VLD);
    end
    send_byte(8'hBB);
    send_byte(8'h00);
    checks++;
    if ({RF_RD_EN, RF_WR_EN, RF_ADDR, CLK_GATE_EN} !== {1'b1, 1'b0, 4'h0, 1'b0}) begin
      failures++;
      $display("FAIL fresh_read: rd=%b wr=%b addr=%h gate=%b, want 1 0 0 0", RF_RD_EN, RF_WR_EN, RF_ADDR, CLK_GATE_EN);
    end
    RF_RD_DATA = 8'h99; RF_RD_VLD = 1'b1;
    tick();
    RF_RD_VLD = 1'b0;
    TX_READY = 1'b1;
    tick();
    TX_READY = 1'b0;
    checks++;
    if (tx_q.size() != 1 || tx_q[0] !== 8'h99 || TX_D_VLD !== 1'b0) begin
      failures++;
      $display("FAIL fresh_read_tx: size=%0d b0=%h txv=%b, want 1 99 0", tx_q.size(), tx_q[0], TX_D_VLD);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_alu_ops();
    test_alu_nop();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_cmd_sequencer.md
# uart_cmd_sequencer

Command sequencer between the UART receiver's parallel output and the system's register file, ALU and UART transmitter. Parses multi-byte command frames delivered by the receiver, issues the register-file write/read and ALU strobes, gates the ALU clock, and returns read or ALU results to the transmitter. It is the only consumer of received bytes and the only producer of transmitted bytes.

## Interface
- DATA_WIDTH, 8, byte width on RX/TX and register-file data
- ADDR_WIDTH, 4, register-file address width
- CLK  in  1  system clock
- RST  in  1  reset; synchronous, active-high
- RX_P_DATA  in  DATA_WIDTH  received byte; valid only with RX_D_VLD
- RX_D_VLD  in  1  one-cycle pulse per received, error-free byte
- RF_WR_EN / RF_RD_EN  out  1  one-cycle register-file strobes
- RF_ADDR  out  ADDR_WIDTH  register-file address
- RF_WR_DATA  out  DATA_WIDTH  register-file write data
- RF_RD_DATA  in  DATA_WIDTH  read data; valid with RF_RD_VLD
- RF_RD_VLD  in  1  read-data pulse, any latency ≥1 cycle after RF_RD_EN
- ALU_EN  out  1  one-cycle ALU start strobe
- ALU_FUN  out  4  ALU function code
- ALU_OUT  in  2*DATA_WIDTH  ALU result; valid with ALU_OUT_VLD
- ALU_OUT_VLD  in  1  result pulse, any latency ≥1 cycle after ALU_EN
- CLK_GATE_EN  out  1  ALU clock-gate enable
- TX_P_DATA  out  DATA_WIDTH  byte to transmit
- TX_D_VLD  out  1  transmit request; held until accepted
- TX_READY  in  1  transmitter ready; byte accepted when TX_D_VLD && TX_READY
- CMD_DROP  out  1  one-cycle pulse when a received byte is discarded

## Operation
- Opcodes (first byte): 0xAA write = {op, addr, data}; 0xBB read = {op, addr}; 0xCC ALU with operands = {op, A, B, fun}; 0xDD ALU no operand = {op, fun}.
- Address bytes use low ADDR_WIDTH bits; fun bytes use low 4 bits; upper bits ignored.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN, ALU_WAIT, TX_LO, TX_HI, TX_RD.
- IDLE: byte 0xAA→WR_ADDR, 0xBB→RD_ADDR, 0xCC→OP_A, 0xDD→ALU_FUN; any other byte → stay, pulse CMD_DROP.
- WR_ADDR: latch addr → WR_DATA. WR_DATA: issue write → IDLE.
- RD_ADDR: issue read → RD_WAIT. RD_WAIT: on RF_RD_VLD latch RF_RD_DATA → TX_RD. TX_RD: present byte; on acceptance → IDLE.
- OP_A: write A to address 0 → OP_B. OP_B: write B to address 1 → ALU_FUN.
- ALU_FUN: issue ALU_EN with fun → ALU_WAIT. ALU_WAIT: on ALU_OUT_VLD latch ALU_OUT → TX_LO.
- TX_LO sends ALU_OUT[7:0], then TX_HI sends ALU_OUT[15:8], then IDLE.
- CLK_GATE_EN high from entry to OP_A (0xCC) or ALU_FUN (0xDD) through the cycle ALU_OUT_VLD is seen; low otherwise.
- RX_D_VLD in RD_WAIT, ALU_WAIT, TX_*: byte discarded, CMD_DROP pulsed, state unchanged.
- No timeout; a missing RF_RD_VLD/ALU_OUT_VLD holds the FSM until RST.
- RF_RD_VLD / ALU_OUT_VLD outside their wait state: ignored.

## Timing
- All outputs registered. Reset: every output 0, state IDLE, latched address/result 0.
- RF_WR_EN/RF_RD_EN/ALU_EN asserted the cycle after the RX_D_VLD of the completing byte; RF_ADDR/RF_WR_DATA/ALU_FUN valid that same cycle and held until the next strobe.
- TX_D_VLD rises the cycle after the result pulse; TX_P_DATA stable while TX_D_VLD high; next byte (TX_HI) presented the cycle after acceptance, TX_D_VLD staying high if immediately available.
- Back-to-back RX_D_VLD on consecutive cycles accepted in all parsing states.
- RST mid-frame: next cycle IDLE, all strobes/TX_D_VLD/CLK_GATE_EN low; partial frame discarded.
- RX_D_VLD coincident with TX acceptance in TX_RD/TX_HI: byte dropped (FSM not yet IDLE).

## Structure
- Shared package: opcode constants (0xAA/0xBB/0xCC/0xDD), operand addresses 0 and 1, state encoding, ALU_FUN width.
- Single module; no sub-module — one FSM plus result/address holding registers.

## Test plan
- RST, bytes AA,05,3C → RF_WR_EN one cycle, RF_ADDR=5, RF_WR_DATA=0x3C; CLK_GATE_EN stays 0.
- Bytes BB,02; RF_RD_VLD with 0x7E after 3 cycles; TX_READY low 4 cycles then high → TX_D_VLD held, one transfer of 0x7E.
- Bytes CC,12,34,01; ALU_OUT=0xABCD after 2 cycles → writes 0x12@0, 0x34@1, ALU_EN with fun 1, TX bytes 0xCD then 0xAB; CLK_GATE_EN high OP_A through result.
- Bytes DD,03 → ALU_EN, ALU_FUN=3, no RF writes; byte 0x55 during ALU_WAIT → CMD_DROP pulse, state held.
- Byte 0x11 in IDLE → CMD_DROP, no strobes; then AA,01,FF works normally.
- RST asserted after CC,12 → next cycle all outputs 0; following BB,00 processed as fresh read.
